// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the boot/run sequencer of the single-cycle MIPS core.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } run_state_t;

  // MIPS "break" encoding; the core stops in front of it.
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000D;

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchronizer for an asynchronous board input, with a one-cycle
// pulse on the synchronized rising edge.
module input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_signal,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   level_prev;

  // The extra flop after the chain remembers last cycle's level for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      level_prev <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_signal};
      level_prev <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = sync_chain[SYNC_STAGES-1] & ~level_prev;

endmodule

// File: rtl/run_controller.sv
// Boot/run sequencer: streams a program into instruction memory, then gates the
// core in free-run, pause and single-step modes until a halt word is reached.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int          IMEM_DEPTH  = 64,
  parameter int          COUNT_WIDTH = 7,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_switch,
  input  logic                   step_button,
  input  logic                   load_valid,
  input  logic [31:0]            load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   imem_write_enabled,
  output logic [31:0]            imem_load_address,
  output logic [31:0]            imem_load_data,
  output logic                   imem_select_pc,
  output logic                   pc_reset,
  output logic                   cpu_advance,
  input  logic [31:0]            current_instr,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] loaded_words,
  output logic [31:0]            cycle_count,
  output logic                   err_overflow
);

  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(IMEM_DEPTH);

  run_state_t             state;
  logic                   run_sync;
  logic                   run_rise_unused;
  logic                   step_level_unused;
  logic                   step_fire;
  logic                   at_halt;
  logic                   load_full;
  logic                   load_accept;
  logic                   advance_request;
  logic [COUNT_WIDTH-1:0] words_next;
  logic [31:0]            cycle_count_q;

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
    .clock        (clock),
    .reset        (reset),
    .async_signal (run_switch),
    .level        (run_sync),
    .rise         (run_rise_unused)
  );

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clock        (clock),
    .reset        (reset),
    .async_signal (step_button),
    .level        (step_level_unused),
    .rise         (step_fire)
  );

  assign at_halt     = (current_instr == HALT_WORD);
  assign load_full   = (loaded_words == DEPTH_COUNT);
  assign load_accept = load_valid & load_ready & (state == ST_LOAD);
  assign words_next  = loaded_words + COUNT_WIDTH'(1);

  assign imem_write_enabled = load_accept;
  assign imem_load_address  = 32'(loaded_words);
  assign imem_load_data     = load_data;
  assign imem_select_pc     = (state != ST_LOAD);
  assign halted             = (state == ST_HALT);
  assign cycle_count        = cycle_count_q;

  // A single step out of READY must release the PC in the same cycle it advances.
  assign pc_reset = (state == ST_LOAD) | ((state == ST_READY) & ~step_fire);

  always_comb begin
    advance_request = 1'b0;
    case (state)
      ST_READY, ST_PAUSE: advance_request = step_fire;
      ST_RUN:             advance_request = 1'b1;
      default:            advance_request = 1'b0;
    endcase
  end

  // Never execute the halt word, so the PC stays parked on it.
  assign cpu_advance = advance_request & ~at_halt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_LOAD;
      load_ready    <= 1'b0;
      loaded_words  <= '0;
      cycle_count_q <= '0;
      err_overflow  <= 1'b0;
    end else begin
      if (cpu_advance && (cycle_count_q != 32'hFFFF_FFFF)) begin
        cycle_count_q <= cycle_count_q + 32'd1;
      end

      if (load_valid && ((state != ST_LOAD) || load_full)) begin
        err_overflow <= 1'b1;
      end

      case (state)
        ST_LOAD: begin
          if (load_accept) begin
            loaded_words <= words_next;
            if (load_last || (words_next == DEPTH_COUNT)) begin
              state      <= ST_READY;
              load_ready <= 1'b0;
            end else begin
              load_ready <= 1'b1;
            end
          end else begin
            load_ready <= ~load_full;
          end
        end
        ST_READY: begin
          if (step_fire && at_halt) begin
            state <= ST_HALT;
          end else if (run_sync) begin
            state <= ST_RUN;
          end else if (step_fire) begin
            state <= ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (at_halt) begin
            state <= ST_HALT;
          end else if (!run_sync) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (step_fire && at_halt) begin
            state <= ST_HALT;
          end else if (run_sync) begin
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: a modelled instruction memory and PC act
// as the core, expected writes and advances are queued by the stimulus side.
module tb_run_controller;

  localparam int          DEPTH = 64;
  localparam logic [31:0] HALT  = 32'h0000_000D;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        run_switch;
  logic        step_button;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        imem_write_enabled;
  logic [31:0] imem_load_address;
  logic [31:0] imem_load_data;
  logic        imem_select_pc;
  logic        pc_reset;
  logic        cpu_advance;
  logic [31:0] current_instr;
  logic        halted;
  logic [6:0]  loaded_words;
  logic [31:0] cycle_count;
  logic        err_overflow;

  int          checks;
  int          errors;
  int          model_words;
  logic [31:0] model_count;
  wr_t         wr_q[$];
  logic [31:0] adv_q[$];
  wr_t         wr_e;
  logic [31:0] adv_e;

  logic [31:0] tb_mem [DEPTH];
  logic [31:0] tb_pc;
  logic [31:0] prog [12];

  run_controller dut (
    .clock              (clock),
    .reset              (reset),
    .run_switch         (run_switch),
    .step_button        (step_button),
    .load_valid         (load_valid),
    .load_data          (load_data),
    .load_last          (load_last),
    .load_ready         (load_ready),
    .imem_write_enabled (imem_write_enabled),
    .imem_load_address  (imem_load_address),
    .imem_load_data     (imem_load_data),
    .imem_select_pc     (imem_select_pc),
    .pc_reset           (pc_reset),
    .cpu_advance        (cpu_advance),
    .current_instr      (current_instr),
    .halted             (halted),
    .loaded_words       (loaded_words),
    .cycle_count        (cycle_count),
    .err_overflow       (err_overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  // Stand-in for the core: instruction memory plus a PC.
  always @(posedge clock) begin
    if (imem_write_enabled === 1'b1) tb_mem[imem_load_address[5:0]] <= imem_load_data;
  end

  always @(posedge clock) begin
    if (pc_reset) tb_pc <= 32'd0;
    else if (cpu_advance) tb_pc <= tb_pc + 32'd1;
  end

  assign current_instr = imem_select_pc ? tb_mem[tb_pc[5:0]] : 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe and every advance must match a queued expectation.
  always @(negedge clock) begin
    #1;
    if (imem_write_enabled === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", imem_load_address, imem_load_data);
      end else begin
        wr_e = wr_q.pop_front();
        checkOutput("write_addr", imem_load_address, wr_e.addr);
        checkOutput("write_data", imem_load_data, wr_e.data);
      end
    end
    if (cpu_advance === 1'b1) begin
      if (adv_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_advance: got cpu_advance=1 at count %h, required 0", cycle_count);
      end else begin
        adv_e = adv_q.pop_front();
        checkOutput("advance_count", cycle_count, adv_e);
      end
    end
  end

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h2000_0000;
    return w;
  endfunction

  task automatic pushAdvance();
    adv_q.push_back(model_count);
    if (model_count != 32'hFFFF_FFFF) model_count = model_count + 32'd1;
  endtask

  // Offer one load beat, waiting for load_ready; called on a negedge.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int  waited;
    wr_t e;
    waited = 0;
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    while (load_ready !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (load_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_ready_timeout: got load_ready=%b, required 1", load_ready);
    end else begin
      e.addr = 32'(model_words);
      e.data = data;
      wr_q.push_back(e);
      model_words++;
      @(negedge clock);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic pressStep(input int hold);
    step_button = 1'b1;
    repeat (hold) @(negedge clock);
    step_button = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic runFor(input int cycles);
    for (int i = 0; i < cycles; i++) pushAdvance();
    run_switch = 1'b1;
    repeat (cycles) @(negedge clock);
    run_switch = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic waitHalted(input int bound);
    int waited;
    waited = 0;
    while (halted !== 1'b1 && waited < bound) begin
      @(negedge clock);
      waited++;
    end
    if (halted !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL halt_timeout: got halted=%b, required 1", halted);
    end
  endtask

  task automatic waitDrain(input int bound);
    int waited;
    waited = 0;
    while ((wr_q.size() != 0 || adv_q.size() != 0) && waited < bound) begin
      @(negedge clock);
      waited++;
    end
    if (wr_q.size() != 0 || adv_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d writes and %0d advances pending, required 0", wr_q.size(), adv_q.size());
      wr_q.delete();
      adv_q.delete();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_load_ready"}, 32'(load_ready), 32'd0);
    checkOutput({tag, "_loaded_words"}, 32'(loaded_words), 32'd0);
    checkOutput({tag, "_cycle_count"}, cycle_count, 32'd0);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
    checkOutput({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
    checkOutput({tag, "_pc_reset"}, 32'(pc_reset), 32'd1);
    checkOutput({tag, "_select_pc"}, 32'(imem_select_pc), 32'd0);
    checkOutput({tag, "_write_en"}, 32'(imem_write_enabled), 32'd0);
    checkOutput({tag, "_advance"}, 32'(cpu_advance), 32'd0);
  endtask

  task automatic applyReset(input string tag);
    reset = 1'b1;
    #2;
    checkResetValues(tag);
    @(negedge clock);
    reset       = 1'b0;
    model_words = 0;
    model_count = 32'd0;
  endtask

  initial begin
    int r;
    checks      = 0;
    errors      = 0;
    model_words = 0;
    model_count = 32'd0;
    reset       = 1'b1;
    run_switch  = 1'b0;
    step_button = 1'b0;
    load_valid  = 1'b0;
    load_data   = 32'd0;
    load_last   = 1'b0;
    #1;
    checkResetValues("power_on");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Load a three-word program ending in the halt word
    applyStimulus(32'h2009_0005, 1'b0);
    applyStimulus(32'h2129_0001, 1'b0);
    applyStimulus(32'h0000_000D, 1'b1);
    checkOutput("t1_loaded_words", 32'(loaded_words), 32'd3);
    checkOutput("t1_pc_reset", 32'(pc_reset), 32'd1);
    checkOutput("t1_select_pc", 32'(imem_select_pc), 32'd1);
    checkOutput("t1_load_ready", 32'(load_ready), 32'd0);
    waitDrain(10);

    // Free run: advance starts three cycles after the switch, stops before the halt word
    pushAdvance();
    pushAdvance();
    run_switch = 1'b1;
    @(negedge clock);
    checkOutput("t2_advance_c1", 32'(cpu_advance), 32'd0);
    @(negedge clock);
    checkOutput("t2_advance_c2", 32'(cpu_advance), 32'd0);
    checkOutput("t2_pc_reset_c2", 32'(pc_reset), 32'd1);
    @(negedge clock);
    checkOutput("t2_advance_c3", 32'(cpu_advance), 32'd1);
    checkOutput("t2_pc_reset_c3", 32'(pc_reset), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("t2_instr_at_halt", current_instr, HALT);
    checkOutput("t2_advance_at_halt", 32'(cpu_advance), 32'd0);
    checkOutput("t2_count_at_halt", cycle_count, 32'd2);
    @(negedge clock);
    checkOutput("t2_halted", 32'(halted), 32'd1);
    run_switch = 1'b0;
    pressStep(2);
    repeat (4) @(negedge clock);
    checkOutput("t2_still_halted", 32'(halted), 32'd1);
    checkOutput("t2_count_held", cycle_count, 32'd2);
    waitDrain(10);

    // Reset after two accepted beats, with a third beat on the bus
    applyReset("t5_pre");
    applyStimulus(randWord(), 1'b0);
    applyStimulus(randWord(), 1'b0);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = randWord();
    #2;
    checkResetValues("t5_mid_load");
    @(negedge clock);
    load_valid  = 1'b0;
    reset       = 1'b0;
    model_words = 0;
    model_count = 32'd0;
    waitDrain(10);

    // Reload from address 0 a twelve-word program with the halt word last
    for (int i = 0; i < 11; i++) prog[i] = randWord();
    prog[11] = HALT;
    for (int i = 0; i < 12; i++) applyStimulus(prog[i], (i == 11));
    checkOutput("t3_loaded_words", 32'(loaded_words), 32'd12);
    waitDrain(10);

    // Step out of READY, run, pause, single-step, then run into the halt word
    pushAdvance();
    pressStep($urandom_range(1, 6));
    checkOutput("t3_pause_pc_reset", 32'(pc_reset), 32'd0);
    r = $urandom_range(2, 6);
    runFor(r);
    checkOutput("t3_paused_advance", 32'(cpu_advance), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pushAdvance();
      pressStep($urandom_range(1, 6));
    end
    waitDrain(10);
    checkOutput("t3_count_after_steps", cycle_count, 32'(4 + r));
    checkOutput("t3_not_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 11 - (4 + r); i++) pushAdvance();
    run_switch = 1'b1;
    waitHalted(100);
    checkOutput("t3_halt_count", cycle_count, 32'd11);
    checkOutput("t3_halt_advance", 32'(cpu_advance), 32'd0);
    run_switch = 1'b0;
    waitDrain(10);

    // Fill memory without load_last, then offer one beat too many
    applyReset("t4_pre");
    for (int i = 0; i < DEPTH; i++) applyStimulus(randWord(), 1'b0);
    checkOutput("t4_loaded_words", 32'(loaded_words), 32'd64);
    checkOutput("t4_load_ready", 32'(load_ready), 32'd0);
    checkOutput("t4_select_pc", 32'(imem_select_pc), 32'd1);
    checkOutput("t4_err_before", 32'(err_overflow), 32'd0);
    load_valid = 1'b1;
    load_data  = randWord();
    @(negedge clock);
    load_valid = 1'b0;
    @(negedge clock);
    checkOutput("t4_err_after", 32'(err_overflow), 32'd1);
    checkOutput("t4_loaded_words_after", 32'(loaded_words), 32'd64);
    waitDrain(10);

    // Preload the counter just below saturation and keep advancing
    pushAdvance();
    pressStep(2);
    waitDrain(10);
    force dut.cycle_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_count_q;
    model_count = 32'hFFFF_FFFE;
    @(negedge clock);
    checkOutput("t6_preload", cycle_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      pushAdvance();
      pressStep($urandom_range(1, 4));
    end
    runFor($urandom_range(2, 5));
    waitDrain(10);
    checkOutput("t6_saturated", cycle_count, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Boot/run sequencer for the single-cycle MIPS core; replaces direct wiring of the board run switch.
- Streams a program into instruction memory through a valid/ready handshake.
- Holds the PC in reset until the program is loaded, then gates execution in free-run, pause and single-step modes.
- Detects a halt instruction and freezes the core; counts executed instructions.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words.
- COUNT_WIDTH, 7, width of loaded_words; must satisfy 2^COUNT_WIDTH > IMEM_DEPTH.
- SYNC_STAGES, 2, flops in each board-input synchronizer (>=2).
- HALT_WORD, 32'h0000000D, instruction encoding that stops the core (MIPS break).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- run_switch  in  1  asynchronous board switch; 1 = run
- step_button  in  1  asynchronous board button; each rising edge = one step
- load_valid  in  1  load beat present
- load_data  in  32  instruction word for the current beat
- load_last  in  1  qualifies the final beat of a program
- load_ready  out  1  controller accepts a beat this cycle
- imem_write_enabled  out  1  instruction memory write strobe
- imem_load_address  out  32  word address of the write, zero-extended
- imem_load_data  out  32  write data
- imem_select_pc  out  1  imem address mux select; 1 = PC, 0 = loader
- pc_reset  out  1  holds the PC at 0
- cpu_advance  out  1  enables PC increment and architectural writes this cycle
- current_instr  in  32  instruction memory output
- halted  out  1  core stopped on HALT_WORD
- loaded_words  out  COUNT_WIDTH  number of words written
- cycle_count  out  32  number of cycles with cpu_advance=1
- err_overflow  out  1  sticky; a beat was offered with no room or after loading ended

Behaviour:
- Reset values:
  - state=LOAD, load_ready=0, loaded_words=0, cycle_count=0, halted=0, err_overflow=0.
  - All synchronizer flops cleared to 0.
- States: LOAD, READY, RUN, PAUSE, HALT. State is registered; outputs are decoded from state except the write strobe and cpu_advance.
- Synchronizers:
  - run_switch and step_button each pass through SYNC_STAGES flops.
  - step_fire is a one-cycle pulse on the synchronized rising edge of step_button.
  - A switch change affects state SYNC_STAGES+1 cycles after it occurs.
- LOAD:
  - load_ready is registered. It equals 1 when in LOAD and the next loaded_words < IMEM_DEPTH.
  - A beat is accepted when load_valid & load_ready. On acceptance: imem_write_enabled=1 in the same cycle, imem_load_address=loaded_words, imem_load_data=load_data, and loaded_words increments.
  - An accepted beat with load_last=1, or loaded_words reaching IMEM_DEPTH, moves to READY on the next cycle.
  - imem_select_pc=0 and pc_reset=1 throughout LOAD.
- READY:
  - pc_reset=1, imem_select_pc=1.
  - run_sync=1 moves to RUN.
  - step_fire moves to PAUSE, with one cpu_advance asserted that cycle (pc_reset deasserted that cycle).
- RUN:
  - pc_reset=0, cpu_advance=1 every cycle.
  - run_sync=0 moves to PAUSE; the PC is held, not reset.
- PAUSE:
  - pc_reset=0; cpu_advance=1 only on a step_fire cycle.
  - run_sync=1 returns to RUN.
- Halt detection:
  - cpu_advance is forced to 0 whenever current_instr==HALT_WORD, so the halt word is never executed and the PC stays on it.
  - If the core is in RUN, or in READY/PAUSE with step_fire, while current_instr==HALT_WORD, the state moves to HALT next cycle.
- HALT:
  - halted=1, cpu_advance=0, pc_reset=0.
  - Only reset leaves HALT.
- load_valid asserted when in any state other than LOAD, or in LOAD while loaded_words==IMEM_DEPTH, sets err_overflow. The beat is not written.
- cycle_count increments on every cycle with cpu_advance=1 and saturates at 32'hFFFFFFFF.
- step_fire while in RUN is ignored.
- Simultaneous step_fire and run_sync rising in PAUSE: one advance that cycle, then RUN.
- Reset mid-load: partially written words remain in memory but loaded_words=0; the program is reloaded from address 0.

Decomposition:
- Package run_ctrl_pkg:
  - State encoding constants (LOAD=0, READY=1, RUN=2, PAUSE=3, HALT=4; 3 bits).
  - Default HALT_WORD.
- Sub-module input_sync: SYNC_STAGES-deep synchronizer with a rising-edge pulse output. Instantiated twice: run_switch (level output used) and step_button (pulse output used).

Test Plan:
1. Load 0x20090005, 0x21290001, 0x0000000D, with load_last on the third beat -> writes at addresses 0, 1, 2 with that data; loaded_words=3; state READY; pc_reset=1; imem_select_pc=1.
2. After test 1, raise run_switch -> cpu_advance=1 and pc_reset=0 exactly 3 cycles later; cycle_count=2 when current_instr becomes 0x0000000D; cpu_advance=0 in that cycle; halted=1 the next cycle; cycle_count stays at 2.
3. RUN, then drop run_switch -> PAUSE with the PC held. Three step_button presses -> exactly 3 single-cycle cpu_advance pulses; cycle_count increases by 3; holding the button produces no extra pulses.
4. IMEM_DEPTH=4, offer 5 beats without load_last -> 4 writes at addresses 0–3; load_ready drops after the 4th; READY; the 5th beat sets err_overflow=1 with no write.
5. Assert reset after 2 accepted beats -> all outputs at reset values immediately; no write strobe during reset; the reload starts again at address 0.
6. Preload cycle_count near saturation (run long, or force) -> the count holds at 32'hFFFFFFFF and does not wrap.
